// File: rtl/wb_arbiter.sv
// rtl/wb_arbiter.sv - writeback arbiter: mem/alu results into an in-order FIFO,
// drained one register-file write per cycle, with newest-wins forwarding lookup.
module wb_arbiter #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 4,
  parameter int AW     = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              alu_valid,
  output logic              alu_ready,
  input  logic [AW-1:0]     alu_rd,
  input  logic [DATA_W-1:0] alu_data,
  input  logic              mem_valid,
  output logic              mem_ready,
  input  logic [AW-1:0]     mem_rd,
  input  logic [DATA_W-1:0] mem_data,
  output logic              reg_write,
  output logic [AW-1:0]     write_register,
  output logic [DATA_W-1:0] write_data,
  input  logic [AW-1:0]     fwd_rs,
  output logic              fwd_hit,
  output logic [DATA_W-1:0] fwd_data,
  output logic              busy
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [AW-1:0]     rd_mem_q   [DEPTH];
  logic [DATA_W-1:0] data_mem_q [DEPTH];
  logic [CW-1:0]     count_q, count_d;
  logic [PW-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic              reg_write_q, reg_write_d;
  logic [AW-1:0]     write_register_q, write_register_d;
  logic [DATA_W-1:0] write_data_q, write_data_d;

  logic              not_full, mem_fire, alu_fire, push, pop;
  logic [AW-1:0]     push_rd;
  logic [DATA_W-1:0] push_data;
  logic [PW-1:0]     idx;

  // Readiness comes from the pre-edge count only; a same-edge pop never frees a slot.
  assign not_full  = count_q < CW'(DEPTH);
  assign mem_ready = not_full;
  assign alu_ready = not_full & ~mem_valid;
  assign mem_fire  = mem_valid & mem_ready;
  assign alu_fire  = alu_valid & alu_ready;
  assign push_rd   = mem_fire ? mem_rd : alu_rd;
  assign push_data = mem_fire ? mem_data : alu_data;
  // x0 handshakes complete but are dropped here.
  assign push      = (mem_fire | alu_fire) & (push_rd != '0);
  assign pop       = count_q != '0;

  always_comb begin
    count_d          = count_q + CW'(push) - CW'(pop);
    wr_ptr_d         = wr_ptr_q + PW'(push);
    rd_ptr_d         = rd_ptr_q + PW'(pop);
    reg_write_d      = pop;
    write_register_d = write_register_q;
    write_data_d     = write_data_q;
    if (pop) begin
      write_register_d = rd_mem_q[rd_ptr_q];
      write_data_d     = data_mem_q[rd_ptr_q];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q          <= '0;
      wr_ptr_q         <= '0;
      rd_ptr_q         <= '0;
      reg_write_q      <= 1'b0;
      write_register_q <= '0;
      write_data_q     <= '0;
    end else begin
      count_q          <= count_d;
      wr_ptr_q         <= wr_ptr_d;
      rd_ptr_q         <= rd_ptr_d;
      reg_write_q      <= reg_write_d;
      write_register_q <= write_register_d;
      write_data_q     <= write_data_d;
    end
  end

  // Storage needs no reset: entries are only ever read below count_q.
  always_ff @(posedge clk) begin
    if (push) begin
      rd_mem_q[wr_ptr_q]   <= push_rd;
      data_mem_q[wr_ptr_q] <= push_data;
    end
  end

  assign reg_write      = reg_write_q;
  assign write_register = write_register_q;
  assign write_data     = write_data_q;
  assign busy           = pop | reg_write_q;

  // Scan oldest to youngest so the newest match overwrites earlier ones.
  always_comb begin
    fwd_hit  = 1'b0;
    fwd_data = '0;
    idx      = '0;
    if (fwd_rs != '0) begin
      if (reg_write_q && write_register_q == fwd_rs) begin
        fwd_hit  = 1'b1;
        fwd_data = write_data_q;
      end
      for (int i = 0; i < DEPTH; i++) begin
        idx = rd_ptr_q + PW'(i);
        if (CW'(i) < count_q && rd_mem_q[idx] == fwd_rs) begin
          fwd_hit  = 1'b1;
          fwd_data = data_mem_q[idx];
        end
      end
    end
  end

endmodule

// File: tb/tb_wb_arbiter.sv
// tb/tb_wb_arbiter.sv - self-checking bench for wb_arbiter: queue-based reference
// model compared every negedge, plus literal checks on the directed scenarios.
module tb_wb_arbiter;

  localparam int DW = 32;
  localparam int DEPTH = 4;
  localparam int AW = 5;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          alu_valid, mem_valid;
  logic          alu_ready, mem_ready;
  logic [AW-1:0] alu_rd, mem_rd, fwd_rs;
  logic [DW-1:0] alu_data, mem_data;
  logic          reg_write, fwd_hit, busy;
  logic [AW-1:0] write_register;
  logic [DW-1:0] write_data, fwd_data;

  wb_arbiter #(.DATA_W(DW), .DEPTH(DEPTH), .AW(AW)) dut (
    .clk(clk), .rst_n(rst_n),
    .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_rd(alu_rd), .alu_data(alu_data),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_rd(mem_rd), .mem_data(mem_data),
    .reg_write(reg_write), .write_register(write_register), .write_data(write_data),
    .fwd_rs(fwd_rs), .fwd_hit(fwd_hit), .fwd_data(fwd_data), .busy(busy)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: pending results as a plain queue, plus the write port image.
  typedef struct packed { logic [AW-1:0] rd; logic [DW-1:0] data; } entry_t;
  entry_t        pend[$];
  logic          m_rw;
  logic [AW-1:0] m_wr;
  logic [DW-1:0] m_wd;
  int            max_pend = 0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend.delete();
      m_rw = 1'b0; m_wr = '0; m_wd = '0;
    end else begin
      bit room, take_mem, take_alu;
      entry_t e;
      room     = pend.size() < DEPTH;
      take_mem = mem_valid && room;
      take_alu = alu_valid && room && !mem_valid;
      if (pend.size() > 0) begin
        e = pend.pop_front();
        m_rw = 1'b1; m_wr = e.rd; m_wd = e.data;
      end else begin
        m_rw = 1'b0;
      end
      if (take_mem && mem_rd != 0) pend.push_back({mem_rd, mem_data});
      else if (take_alu && alu_rd != 0) pend.push_back({alu_rd, alu_data});
      if (pend.size() > max_pend) max_pend = pend.size();
    end
  end

  always @(negedge clk) begin
    bit          room, e_hit;
    logic [DW-1:0] e_fd;
    room  = pend.size() < DEPTH;
    e_hit = 1'b0; e_fd = '0;
    if (fwd_rs != 0) begin
      if (m_rw && m_wr == fwd_rs) begin e_hit = 1'b1; e_fd = m_wd; end
      foreach (pend[i]) if (pend[i].rd == fwd_rs) begin e_hit = 1'b1; e_fd = pend[i].data; end
    end
    chk("mem_ready", 32'(mem_ready), 32'(room));
    chk("alu_ready", 32'(alu_ready), 32'(room && !mem_valid));
    chk("reg_write", 32'(reg_write), 32'(m_rw));
    chk("write_register", 32'(write_register), 32'(m_wr));
    chk("write_data", write_data, m_wd);
    chk("busy", 32'(busy), 32'(pend.size() != 0 || m_rw));
    chk("fwd_hit", 32'(fwd_hit), 32'(e_hit));
    chk("fwd_data", fwd_data, e_fd);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    alu_valid = 0; mem_valid = 0;
  endtask

  initial begin
    rst_n = 0; idle(); alu_rd = 0; alu_data = 0; mem_rd = 0; mem_data = 0; fwd_rs = 0;
    repeat (2) step();
    rst_n = 1;
    @(negedge clk); #1;
    chk("lit reset reg_write", 32'(reg_write), 32'd0);
    chk("lit reset write_register", 32'(write_register), 32'd0);
    chk("lit reset busy", 32'(busy), 32'd0);

    // Single ALU op: visible two edges after the handshake, for one cycle.
    step();
    alu_valid = 1; alu_rd = 3; alu_data = 32'hDEADBEEF;
    step();
    idle();
    @(negedge clk); #1;
    chk("lit lat reg_write early", 32'(reg_write), 32'd0);
    step();
    @(negedge clk); #1;
    chk("lit lat reg_write", 32'(reg_write), 32'd1);
    chk("lit lat write_register", 32'(write_register), 32'd3);
    chk("lit lat write_data", write_data, 32'hDEADBEEF);
    step();
    @(negedge clk); #1;
    chk("lit lat one cycle", 32'(reg_write), 32'd0);

    // Simultaneous offers: mem wins, alu follows next edge.
    step();
    mem_valid = 1; mem_rd = 2; mem_data = 32'h22;
    alu_valid = 1; alu_rd = 1; alu_data = 32'h11;
    @(negedge clk); #1;
    chk("lit prio alu_ready", 32'(alu_ready), 32'd0);
    chk("lit prio mem_ready", 32'(mem_ready), 32'd1);
    step();
    mem_valid = 0;
    step();
    alu_valid = 0;
    @(negedge clk); #1;
    chk("lit order first", 32'(write_register), 32'd2);
    chk("lit order first data", write_data, 32'h22);
    step();
    @(negedge clk); #1;
    chk("lit order second", 32'(write_register), 32'd1);
    chk("lit order second rw", 32'(reg_write), 32'd1);
    chk("lit order second data", write_data, 32'h11);

    // Both valid held for six cycles with distinct payloads.
    for (int i = 0; i < 6; i++) begin
      mem_valid = 1; mem_rd = AW'(8 + i); mem_data = 32'h100 + i;
      alu_valid = 1; alu_rd = AW'(20 + i); alu_data = 32'h200 + i;
      fwd_rs = AW'(8 + i);
      step();
    end
    idle();
    repeat (4) step();
    chk("max occupancy", 32'(max_pend <= DEPTH), 32'd1);

    // x0 destination: handshake completes, nothing written.
    alu_valid = 1; alu_rd = 0; alu_data = 32'h55; fwd_rs = 0;
    @(negedge clk); #1;
    chk("lit x0 alu_ready", 32'(alu_ready), 32'd1);
    step();
    idle();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); #1;
      chk("lit x0 no write", 32'(reg_write), 32'd0);
      step();
    end

    // Forwarding: newest of two same-rd results wins.
    fwd_rs = 5;
    alu_valid = 1; alu_rd = 5; alu_data = 32'hA;
    step();
    alu_data = 32'hB;
    step();
    idle();
    @(negedge clk); #1;
    chk("lit fwd_hit", 32'(fwd_hit), 32'd1);
    chk("lit fwd_data", fwd_data, 32'hB);
    repeat (3) step();
    @(negedge clk); #1;
    chk("lit fwd retired", 32'(fwd_hit), 32'd0);

    // Reset mid-stream discards everything in flight.
    for (int i = 0; i < 3; i++) begin
      alu_valid = 1; alu_rd = AW'(10 + i); alu_data = 32'h300 + i;
      step();
    end
    idle();
    #1 rst_n = 0;
    #1;
    chk("lit rst reg_write", 32'(reg_write), 32'd0);
    chk("lit rst busy", 32'(busy), 32'd0);
    step();
    rst_n = 1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); #1;
      chk("lit rst no write", 32'(reg_write), 32'd0);
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: simulation exceeded time budget");
    $fatal(1);
  end

endmodule
